fifo_stream_reader: RTL and testbench

FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

---
 rtl/fifo_stream_reader.sv | 117 +++++++++++
 tb/tb_fifo_stream_reader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// Read side of a synchronous FIFO turned into a valid/ready stream through a 2-entry skid buffer.
// Optional m_parity output (XOR of m_data) is built only when FIFO_STREAM_PARITY_EN is defined.
//
// state    | meaning
// ---------+-------------------------------------------
// ST_EMPTY | no word buffered, m_valid low
// ST_ONE   | one word buffered in head
// ST_TWO   | two words buffered, head is the oldest
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [CNT_WIDTH-1:0]  words_out
`ifdef FIFO_STREAM_PARITY_EN
    ,
    output logic                  m_parity
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } occ_e;

    occ_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    logic                  inflight_q, inflight_d;
    logic                  armed_q;
    logic [CNT_WIDTH-1:0]  count_q, count_d;

    logic                  xfer;
    logic                  capture;
    logic [1:0]            occ;
    logic [1:0]            pending;

    always_comb begin
        occ        = state_q;
        xfer       = (state_q != ST_EMPTY) && m_ready;
        capture    = inflight_q;
        // Slots committed once this cycle settles; a new read is only safe if one stays free.
        pending    = occ + {1'b0, inflight_q} - {1'b0, xfer};
        fifo_rd_en = armed_q && !fifo_empty && (pending < 2'd2);
        inflight_d = fifo_rd_en;
        count_d    = count_q + {{(CNT_WIDTH-1){1'b0}}, xfer};

        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            ST_EMPTY: begin
                if (capture) begin
                    head_d  = fifo_data;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                case ({capture, xfer})
                    2'b11: head_d = fifo_data;
                    2'b10: begin
                        tail_d  = fifo_data;
                        state_d = ST_TWO;
                    end
                    2'b01: state_d = ST_EMPTY;
                    default: ;
                endcase
            end
            ST_TWO: begin
                if (xfer) begin
                    head_d = tail_q;
                    if (capture) begin
                        tail_d = fifo_data;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            head_q     <= '0;
            tail_q     <= '0;
            inflight_q <= 1'b0;
            armed_q    <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            inflight_q <= inflight_d;
            armed_q    <= 1'b1;
            count_q    <= count_d;
        end
    end

    assign m_valid   = (state_q != ST_EMPTY);
    assign m_data    = head_q;
    assign words_out = count_q;

`ifdef FIFO_STREAM_PARITY_EN
    assign m_parity = ^head_q;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench for fifo_stream_reader: behavioural FIFO upstream, expected-word queue,
// monitor forked alongside directed stimulus. Parity checks run when FIFO_STREAM_PARITY_EN is defined.
module tb_fifo_stream_reader;

    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_data = '0;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [CW-1:0] words_out;
`ifdef FIFO_STREAM_PARITY_EN
    logic          m_parity;
`endif

    fifo_stream_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_data  (fifo_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .words_out  (words_out)
`ifdef FIFO_STREAM_PARITY_EN
        ,
        .m_parity   (m_parity)
`endif
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [0:63];
    int            wr_ptr   = 0;
    int            rd_ptr   = 0;
    int            rd_count = 0;
    logic [DW-1:0] exp_q [$];
    int            checks   = 0;
    int            errors   = 0;

    assign fifo_empty = (wr_ptr == rd_ptr);

    // Upstream FIFO with read latency 1.
    always @(posedge clk) begin
        if (fifo_rd_en && !fifo_empty) begin
            fifo_data <= mem[rd_ptr[5:0]];
            rd_ptr    <= rd_ptr + 1;
            rd_count  <= rd_count + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [DW-1:0] w, input bit expect_out);
        mem[wr_ptr[5:0]] = w;
        wr_ptr++;
        if (expect_out) exp_q.push_back(w);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget, input bit toggle);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            if (toggle) m_ready = ~m_ready;
            step();
            n++;
        end
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic monitor();
        logic          prev_stall;
        logic [DW-1:0] prev_data;
        logic [DW-1:0] e;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (fifo_empty) check("rd_while_empty", 32'(fifo_rd_en), 32'd0);
                if (prev_stall) begin
                    check("stall_valid", 32'(m_valid), 32'd1);
                    check("stall_data", m_data, prev_data);
                end
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_word", m_data, 32'hFFFF_FFFF ^ m_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("stream_data", m_data, e);
                    end
                end
                prev_stall = m_valid && !m_ready;
                prev_data  = m_data;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        repeat (2) step();
    endtask

    logic [DW-1:0] stream_words [8] = '{32'hA1A1A1A1, 32'h02020202, 32'h03030303, 32'h04040404,
                                        32'h05050505, 32'h06060606, 32'h07070707, 32'h08080808};
    logic [DW-1:0] alt_words [8]    = '{32'hC1C1C1C1, 32'hC2C2C2C2, 32'hC3C3C3C3, 32'hC4C4C4C4,
                                        32'hC5C5C5C5, 32'hC6C6C6C6, 32'hC7C7C7C7, 32'hC8C8C8C8};

    initial begin
        int rd0;
        rst     = 1'b1;
        m_ready = 1'b0;
        fork
            monitor();
        join_none

        #2;
        check("rst_valid", 32'(m_valid), 32'd0);
        check("rst_data", m_data, 32'd0);
        check("rst_count", 32'(words_out), 32'd0);
        check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        repeat (2) step();
        rst = 1'b0;
        repeat (2) step();

        // Streaming: 8 words, back-to-back, first valid two cycles after empty falls.
        m_ready = 1'b1;
        foreach (stream_words[i]) push(stream_words[i], 1'b1);
        @(negedge clk);
        check("lat_c0_valid", 32'(m_valid), 32'd0);
        @(negedge clk);
        check("lat_c1_valid", 32'(m_valid), 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("b2b_valid", 32'(m_valid), 32'd1);
        end
        step();
        check("stream_count", 32'(words_out), 32'd8);

        // Backpressure: 4 words queued, only 2 reads while stalled.
        m_ready = 1'b0;
        rd0 = rd_count;
        for (int i = 0; i < 4; i++) push(stream_words[i], 1'b1);
        repeat (10) step();
        check("bp_reads", 32'(rd_count - rd0), 32'd2);
        check("bp_valid", 32'(m_valid), 32'd1);
        check("bp_head", m_data, 32'hA1A1A1A1);
        m_ready = 1'b1;
        drain(30, 1'b0);
        step();
        check("bp_count", 32'(words_out), 32'd12);

        // Alternating ready: counter passes 15 -> 0 on the way to 20 mod 16.
        m_ready = 1'b0;
        foreach (alt_words[i]) push(alt_words[i], 1'b1);
        drain(60, 1'b1);
        step();
        check("alt_count", 32'(words_out), 32'd4);

        // Reset with a word buffered and a second in flight.
        m_ready = 1'b0;
        push(32'hDEAD0001, 1'b0);
        push(32'hDEAD0002, 1'b0);
        repeat (2) step();
        #1;
        check("pre_rst_valid", 32'(m_valid), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(m_valid), 32'd0);
        check("mid_rst_data", m_data, 32'd0);
        check("mid_rst_count", 32'(words_out), 32'd0);
        check("mid_rst_rd_en", 32'(fifo_rd_en), 32'd0);
        push(32'h5A5A5A5A, 1'b1);
        repeat (2) step();
        rst     = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);
        check("post_rst_no_read", 32'(fifo_rd_en), 32'd0);
        drain(20, 1'b0);
        repeat (3) step();
        check("post_rst_count", 32'(words_out), 32'd1);
        check("post_rst_empty", 32'(m_valid), 32'd0);

        // Counter wrap: 17 transfers from reset into a 4-bit counter.
        m_ready = 1'b0;
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 17; i++) push(32'h0000_0100 + 32'(i), 1'b1);
        drain(60, 1'b0);
        step();
        check("wrap_count", 32'(words_out), 32'd1);

`ifdef FIFO_STREAM_PARITY_EN
        m_ready = 1'b0;
        push(32'h00000007, 1'b1);
        push(32'hA1A1A1A1, 1'b1);
        repeat (4) step();
        check("par_data7", m_data, 32'h00000007);
        check("par_odd", 32'(m_parity), 32'd1);
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        check("par_dataA1", m_data, 32'hA1A1A1A1);
        check("par_even", 32'(m_parity), 32'd0);
        m_ready = 1'b1;
        drain(20, 1'b0);
`endif

        repeat (2) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
